cam2_fill_ctrl: RTL and testbench
=================================

Name: cam2_fill_ctrl

Overview:
Miss handler and fill engine that drives the cam2 fully-associative cache from the opposite side to its lookup port. It accepts CPU tag reads and returns hits directly from the cache. On a miss it fetches the word from backing memory over a req/ack handshake and writes it into the cache, first evicting a round-robin victim if the cache is full. It sits between the CPU load path, the cam2 instance and the memory bus.

Parameters:
WORDS, 8, number of cache entries (any value ≥2, not necessarily a power of 2)
BITS, 8, data width
TAG_SZ, 8, tag and memory address width
ADDR_LEFT, $clog2(WORDS)-1, MSB of the cache entry index
TIMEOUT, 16, max cycles waiting for mem_ack; 0 disables the timeout

Ports:
clk  input  1  system clock
rst_  input  1  asynchronous active-low reset
cpu_rd  input  1  CPU read request; held with stable cpu_tag until cpu_ready
cpu_tag  input  TAG_SZ  requested tag/address
cpu_data  output  BITS  returned data, valid when cpu_ready=1
cpu_ready  output  1  one-cycle completion strobe
cpu_err  output  1  with cpu_ready: memory timeout, cpu_data=0
check_tag  output  TAG_SZ  to cam2 lookup
read  output  1  to cam2 lookup enable
cache_hit  input  1  from cam2
cache_data  input  BITS  from cam2
cache_full  input  1  from cam2
write_  output  1  active-low cam2 write strobe
w_addr  output  ADDR_LEFT+1  invalidate index
wdata  output  BITS  fill data
new_tag  output  TAG_SZ  fill tag
new_valid  output  1  1=fill, 0=invalidate w_addr
mem_req  output  1  memory read request
mem_addr  output  TAG_SZ  memory address (latched tag)
mem_ack  input  1  memory data valid
mem_rdata  input  BITS  memory data

Behaviour:
- Reset (rst_ is asynchronous, active-low; clock is clk): state=IDLE, victim_ptr=0, tout_cnt=0, tag_q=0, data_q=0. All outputs 0 except write_=1.
- States: IDLE, EVICT, MEM_REQ, FILL, RESP, ERR.
- IDLE: read=cpu_rd; check_tag=cpu_tag (combinational).
  - cpu_rd & cache_hit: cpu_ready=1 and cpu_data=cache_data in the same cycle (0-cycle hit); stay in IDLE.
  - cpu_rd & !cache_hit: tag_q<=cpu_tag; go to EVICT if cache_full, else MEM_REQ. cpu_ready=0.
- EVICT (1 cycle): write_=0, new_valid=0, w_addr=victim_ptr. Then victim_ptr<=(victim_ptr==WORDS-1)?0:victim_ptr+1 and go to MEM_REQ.
- MEM_REQ: mem_req=1, mem_addr=tag_q, held until mem_ack.
  - mem_ack (accepted in the first cycle of mem_req too): data_q<=mem_rdata, go to FILL. mem_req drops the next cycle.
  - tout_cnt clears on entry and increments each cycle without ack. If TIMEOUT≠0 and tout_cnt==TIMEOUT-1 with no ack: go to ERR. mem_ack in that same cycle wins and the state goes to FILL.
- FILL (1 cycle): write_=0, new_valid=1, new_tag=tag_q, wdata=data_q. Go to RESP.
- RESP (1 cycle): cpu_ready=1, cpu_data=data_q. Go to IDLE.
- ERR (1 cycle): cpu_ready=1, cpu_err=1, cpu_data=0, no cache write. Go to IDLE.
- Miss latency, not full: mem_ack cycle + 2 (FILL, RESP). A full cache adds 1 cycle (EVICT).
- In states other than IDLE: read=0 and cpu inputs are ignored. mem_ack outside MEM_REQ is ignored.
- write_ is low only in EVICT or FILL, and exactly one cycle each. The write_/new_valid/w_addr/wdata/new_tag outputs are registered or glitch-free decoded from state. When write_=1 they are 0.
- The cycle after RESP is IDLE. A still-high cpu_rd there is a new request and hits on the filled tag.
- Reset mid-operation: immediate return to IDLE, mem_req and cpu_ready deassert, no partial cache write.

Test Plan:
- Reset, then cpu_rd tag 0x12 on an empty cache -> EVICT skipped, mem_req=1 with mem_addr=0x12; ack after 3 cycles with 0xA5 -> write_=0, new_valid=1, new_tag=0x12, wdata=0xA5 for 1 cycle; next cycle cpu_ready=1, cpu_data=0xA5.
- Repeat read 0x12 -> cpu_ready=1 in the same cycle, cpu_data=0xA5, mem_req stays 0.
- WORDS=4: fill tags 0x01..0x04, then read 0x05 -> EVICT with w_addr=0, new_valid=0, then fill 0x05. Next three misses evict w_addr=1, 2, 3, and the fourth wraps to w_addr=0.
- TIMEOUT=16, mem_ack never asserted -> after 16 MEM_REQ cycles: cpu_ready=1, cpu_err=1, cpu_data=0, no write_ pulse; a later read of the same tag misses again.
- mem_ack asserted in the first MEM_REQ cycle -> FILL next cycle, then RESP; total 3 cycles from the miss cycle.
- Assert rst_=0 during MEM_REQ -> mem_req=0 immediately, victim_ptr=0, no write_ pulse; after release, the next read behaves as in the first scenario.

Source files
------------

// File: rtl/cam2_fill_ctrl_if.sv
// Bundle of the CPU load port, the cam2 lookup/write port and the memory
// read bus seen by the cam2 miss handler. "master" is the fill controller,
// "slave" is everything around it (CPU, cache and memory).
interface cam2_fill_ctrl_if #(
  parameter int BITS   = 8,
  parameter int TAG_SZ = 8,
  parameter int AW     = 3
);
  // CPU load path
  logic              cpu_rd;
  logic [TAG_SZ-1:0] cpu_tag;
  logic [BITS-1:0]   cpu_data;
  logic              cpu_ready;
  logic              cpu_err;
  // cam2 lookup side
  logic [TAG_SZ-1:0] check_tag;
  logic              read;
  logic              cache_hit;
  logic [BITS-1:0]   cache_data;
  logic              cache_full;
  // cam2 write side
  logic              write_;
  logic [AW-1:0]     w_addr;
  logic [BITS-1:0]   wdata;
  logic [TAG_SZ-1:0] new_tag;
  logic              new_valid;
  // memory bus
  logic              mem_req;
  logic [TAG_SZ-1:0] mem_addr;
  logic              mem_ack;
  logic [BITS-1:0]   mem_rdata;

  modport master (
    input  cpu_rd, cpu_tag, cache_hit, cache_data, cache_full, mem_ack, mem_rdata,
    output cpu_data, cpu_ready, cpu_err, check_tag, read,
           write_, w_addr, wdata, new_tag, new_valid, mem_req, mem_addr
  );

  modport slave (
    output cpu_rd, cpu_tag, cache_hit, cache_data, cache_full, mem_ack, mem_rdata,
    input  cpu_data, cpu_ready, cpu_err, check_tag, read,
           write_, w_addr, wdata, new_tag, new_valid, mem_req, mem_addr
  );
endinterface

// File: rtl/cam2_fill_ctrl.sv
// Miss handler / fill engine for the cam2 fully-associative cache.
// Hits return in the request cycle; misses fetch from memory, evict a
// round-robin victim when the cache is full, then fill and respond.
module cam2_fill_ctrl #(
  parameter int WORDS     = 8,
  parameter int BITS      = 8,
  parameter int TAG_SZ    = 8,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst_,
  cam2_fill_ctrl_if.master bus
);

  localparam int AW = ADDR_LEFT + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVICT   = 3'd1,
    MEM_REQ = 3'd2,
    FILL    = 3'd3,
    RESP    = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     victim_q, victim_d;
  logic [TW-1:0]     tout_q, tout_d;
  logic [TAG_SZ-1:0] tag_q, tag_d;
  logic [BITS-1:0]   data_q, data_d;

  // State and datapath registers, cleared asynchronously by rst_
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      victim_q <= '0;
      tout_q   <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      tout_q   <= tout_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic: miss capture, victim advance, memory wait and timeout
  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    tout_d   = '0;          // counter only survives while waiting in MEM_REQ
    tag_d    = tag_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_rd && !bus.cache_hit) begin
          tag_d   = bus.cpu_tag;
          state_d = bus.cache_full ? EVICT : MEM_REQ;
        end
      end
      EVICT: begin
        victim_d = (victim_q == AW'(WORDS - 1)) ? '0 : victim_q + 1'b1;
        state_d  = MEM_REQ;
      end
      MEM_REQ: begin
        if (bus.mem_ack) begin
          // an ack in the timeout cycle still wins
          data_d  = bus.mem_rdata;
          state_d = FILL;
        end else if ((TIMEOUT != 0) && (tout_q == TW'(TIMEOUT - 1))) begin
          state_d = ERR;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      FILL:    state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state; only IDLE passes CPU inputs through
  always_comb begin
    bus.read      = 1'b0;
    bus.check_tag = '0;
    bus.cpu_ready = 1'b0;
    bus.cpu_err   = 1'b0;
    bus.cpu_data  = '0;
    bus.write_    = 1'b1;
    bus.w_addr    = '0;
    bus.wdata     = '0;
    bus.new_tag   = '0;
    bus.new_valid = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    case (state_q)
      IDLE: begin
        // gated by rst_ so a CPU request held during reset cannot leak out
        if (rst_) begin
          bus.read      = bus.cpu_rd;
          bus.check_tag = bus.cpu_tag;
          if (bus.cpu_rd && bus.cache_hit) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_data  = bus.cache_data;
          end
        end
      end
      EVICT: begin
        bus.write_ = 1'b0;
        bus.w_addr = victim_q;
      end
      MEM_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = tag_q;
      end
      FILL: begin
        bus.write_    = 1'b0;
        bus.new_valid = 1'b1;
        bus.new_tag   = tag_q;
        bus.wdata     = data_q;
      end
      RESP: begin
        bus.cpu_ready = 1'b1;
        bus.cpu_data  = data_q;
      end
      ERR: begin
        bus.cpu_ready = 1'b1;
        bus.cpu_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cam2_fill_ctrl.sv
// Randomized self-checking bench for cam2_fill_ctrl with a 4-entry cam2
// model and a transaction-level reference of cache contents and victim order.
module tb_cam2_fill_ctrl;

  localparam int WORDS   = 4;
  localparam int BITS    = 8;
  localparam int TAG_SZ  = 8;
  localparam int AW      = 2;
  localparam int TIMEOUT = 16;
  localparam int NOACK   = 99;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  cam2_fill_ctrl_if #(.BITS(BITS), .TAG_SZ(TAG_SZ), .AW(AW)) bus ();

  cam2_fill_ctrl #(
    .WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAG_SZ),
    .ADDR_LEFT(AW - 1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // cam2 model: first free slot on fill, lookup gated by read
  logic       cv [WORDS] = '{default: 1'b0};
  logic [7:0] ct [WORDS] = '{default: 8'h00};
  logic [7:0] cd [WORDS] = '{default: 8'h00};

  always_comb begin
    bus.cache_hit  = 1'b0;
    bus.cache_data = '0;
    bus.cache_full = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      if (!cv[i]) bus.cache_full = 1'b0;
      if (bus.read && cv[i] && ct[i] == bus.check_tag) begin
        bus.cache_hit  = 1'b1;
        bus.cache_data = cd[i];
      end
    end
  end

  always @(posedge clk) begin
    if (bus.write_ == 1'b0) begin
      if (bus.new_valid) begin
        int f;
        f = -1;
        for (int i = 0; i < WORDS; i++)
          if (!cv[i] && f < 0) f = i;
        if (f >= 0) begin
          cv[f] <= 1'b1;
          ct[f] <= bus.new_tag;
          cd[f] <= bus.wdata;
        end
      end else begin
        cv[bus.w_addr] <= 1'b0;
      end
    end
  end

  // backing memory contents
  logic [7:0] mem [256];

  // reference: which tags the cache should hold, in which slot, and next victim
  logic       rv [WORDS] = '{default: 1'b0};
  logic [7:0] rt [WORDS] = '{default: 8'h00};
  logic [7:0] rdat [WORDS] = '{default: 8'h00};
  int         rvict = 0;

  function automatic int ref_find(input logic [7:0] tag);
    for (int i = 0; i < WORDS; i++)
      if (rv[i] && rt[i] == tag) return i;
    return -1;
  endfunction

  function automatic int ref_count();
    int c = 0;
    for (int i = 0; i < WORDS; i++)
      if (rv[i]) c++;
    return c;
  endfunction

  task automatic ref_insert(input logic [7:0] tag, input logic [7:0] data);
    for (int i = 0; i < WORDS; i++) begin
      if (!rv[i]) begin
        rv[i] = 1'b1; rt[i] = tag; rdat[i] = data;
        return;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // cycle after a miss in IDLE: optional eviction, checked against reference
  task automatic expect_evict();
    if (ref_count() == WORDS) begin
      @(negedge clk);
      check_eq("evict_write_", 32'(bus.write_), 0);
      check_eq("evict_valid", 32'(bus.new_valid), 0);
      check_eq("evict_addr", 32'(bus.w_addr), 32'(rvict));
      check_eq("evict_mreq", 32'(bus.mem_req), 0);
      rv[rvict] = 1'b0;
      rvict = (rvict + 1) % WORDS;
      @(posedge clk); #1;
    end
  endtask

  // one CPU read; d = MEM_REQ cycle index of the ack, NOACK for none
  task automatic do_read(input logic [7:0] tag, input int d);
    int  s;
    bit  acked;
    bus.cpu_rd  = 1'b1;
    bus.cpu_tag = tag;
    bus.mem_ack = 1'b0;
    s = ref_find(tag);
    @(negedge clk);
    check_eq("read", 32'(bus.read), 1);
    check_eq("check_tag", 32'(bus.check_tag), 32'(tag));
    if (s >= 0) begin
      check_eq("hit_ready", 32'(bus.cpu_ready), 1);
      check_eq("hit_data", 32'(bus.cpu_data), 32'(rdat[s]));
      check_eq("hit_mreq", 32'(bus.mem_req), 0);
      @(posedge clk); #1;
      bus.cpu_rd = 1'b0;
      return;
    end
    check_eq("miss_ready", 32'(bus.cpu_ready), 0);
    @(posedge clk); #1;
    expect_evict();
    acked = 1'b0;
    for (int j = 0; j < TIMEOUT; j++) begin
      if (j == d) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[tag];
      end
      @(negedge clk);
      check_eq("mem_req", 32'(bus.mem_req), 1);
      check_eq("mem_addr", 32'(bus.mem_addr), 32'(tag));
      check_eq("wait_ready", 32'(bus.cpu_ready), 0);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (j == d) begin
        acked = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (acked) begin
      check_eq("fill_write_", 32'(bus.write_), 0);
      check_eq("fill_valid", 32'(bus.new_valid), 1);
      check_eq("fill_tag", 32'(bus.new_tag), 32'(tag));
      check_eq("fill_data", 32'(bus.wdata), 32'(mem[tag]));
      check_eq("fill_mreq", 32'(bus.mem_req), 0);
      ref_insert(tag, mem[tag]);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("resp_ready", 32'(bus.cpu_ready), 1);
      check_eq("resp_data", 32'(bus.cpu_data), 32'(mem[tag]));
      check_eq("resp_err", 32'(bus.cpu_err), 0);
      check_eq("resp_write_", 32'(bus.write_), 1);
    end else begin
      check_eq("err_ready", 32'(bus.cpu_ready), 1);
      check_eq("err_flag", 32'(bus.cpu_err), 1);
      check_eq("err_data", 32'(bus.cpu_data), 0);
      check_eq("err_write_", 32'(bus.write_), 1);
    end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
  endtask

  // miss that is interrupted by reset while waiting on memory
  task automatic rst_mid(input logic [7:0] tag);
    bus.cpu_rd  = 1'b1;
    bus.cpu_tag = tag;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    expect_evict();
    @(negedge clk);
    check_eq("pre_rst_mreq", 32'(bus.mem_req), 1);
    #1 rst_ = 1'b0;
    #1;
    check_eq("rst_mreq", 32'(bus.mem_req), 0);
    check_eq("rst_ready", 32'(bus.cpu_ready), 0);
    check_eq("rst_write_", 32'(bus.write_), 1);
    check_eq("rst_read", 32'(bus.read), 0);
    bus.cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst_  = 1'b1;
    rvict = 0;
    @(negedge clk);
    check_eq("post_rst_write_", 32'(bus.write_), 1);
    check_eq("post_rst_mreq", 32'(bus.mem_req), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cpu_rd    = 1'b0;
    bus.cpu_tag   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h12] = 8'hA5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_write_", 32'(bus.write_), 1);
    check_eq("reset_mreq", 32'(bus.mem_req), 0);
    check_eq("reset_ready", 32'(bus.cpu_ready), 0);
    check_eq("reset_err", 32'(bus.cpu_err), 0);
    check_eq("reset_valid", 32'(bus.new_valid), 0);
    check_eq("reset_read", 32'(bus.read), 0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk); #1;

    // first miss on an empty cache, then a same-cycle hit
    do_read(8'h12, 3);
    do_read(8'h12, 0);
    // fill to full, then walk the victim pointer through a wrap
    do_read(8'h01, 1);
    do_read(8'h02, 2);
    do_read(8'h03, 0);
    do_read(8'h05, 2);
    do_read(8'h06, 0);
    do_read(8'h07, 1);
    do_read(8'h08, 0);
    do_read(8'h09, 0);
    // memory never answers, then the same tag misses again
    do_read(8'h40, NOACK);
    do_read(8'h40, 2);
    do_read(8'h41, 0);
    // reset mid-fetch clears the victim pointer
    rst_mid(8'h42);
    do_read(8'h42, 3);
    do_read(8'h43, 1);
    // ack arriving in the very last timeout cycle
    do_read(8'h44, TIMEOUT - 1);

    for (int n = 0; n < 80; n++) begin
      logic [7:0] t;
      int         d;
      t = 8'($urandom_range(0, 11));
      d = ($urandom_range(0, 9) == 0) ? NOACK : int'($urandom_range(0, 4));
      do_read(t, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
